keypad_emulator: RTL

//  Drives the other end of the 4x4 keypad matrix scan interface, for test boards and self-test.
//  - Reads the active-high one-hot column drives from the scanner.
//  - Returns row levels as if a requested hex key were held down.
//  - Key requests arrive over a valid/ready handshake; each is a timed press then release.
//  - A one-cycle done pulse and a press counter report completion.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_key_decode.sv | 21 ++
 rtl/keypad_emulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types and the hex-key to matrix-position map.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } kpemu_state_t;

    // Phase counter width: enough bits for the longer of the two phases, never zero
    function automatic int kp_cnt_w(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

    // Hex key -> {row[1:0], col[1:0]}; rows top to bottom, col3 holds A..D
    function automatic logic [3:0] key_to_rc(input logic [3:0] key);
        logic [3:0] rc;
        case (key)
            4'h1: rc = {2'd0, 2'd0};
            4'h4: rc = {2'd1, 2'd0};
            4'h7: rc = {2'd2, 2'd0};
            4'hE: rc = {2'd3, 2'd0};
            4'h2: rc = {2'd0, 2'd1};
            4'h5: rc = {2'd1, 2'd1};
            4'h8: rc = {2'd2, 2'd1};
            4'h0: rc = {2'd3, 2'd1};
            4'h3: rc = {2'd0, 2'd2};
            4'h6: rc = {2'd1, 2'd2};
            4'h9: rc = {2'd2, 2'd2};
            4'hF: rc = {2'd3, 2'd2};
            4'hA: rc = {2'd0, 2'd3};
            4'hB: rc = {2'd1, 2'd3};
            4'hC: rc = {2'd2, 2'd3};
            default: rc = {2'd3, 2'd3}; // 4'hD
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Turns a hex key into one-hot row and column masks in matrix bit order.
// Latency: combinational.
// Backpressure: n/a.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0] key,
    output logic [3:0] row_mask,
    output logic [3:0] col_mask
);

    logic [3:0] rc;

    // Column k is driven as 4'b1000>>k, row r senses as 4'b1000>>r
    always_comb begin
        rc       = key_to_rc(key);
        row_mask = 4'b1000 >> rc[3:2];
        col_mask = 4'b1000 >> rc[1:0];
    end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a held hex key on a 4x4 scanned matrix: timed press, then release; KEYPAD_EMU_BOUNCE_EN adds LFSR contact bounce.
// Latency: rows follow cols by one clock; done pulses HOLD_CYCLES+RELEASE_CYCLES clocks after a key is accepted.
// Backpressure: key_ready only in IDLE; requests while busy are dropped, not buffered.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 64,
    parameter int RELEASE_CYCLES = 64,
    parameter int BOUNCE_CYCLES  = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    input  logic             abort,
    input  logic [3:0]       cols,
    output logic [3:0]       rows,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] press_count
);

    localparam int            CW        = kp_cnt_w(HOLD_CYCLES, RELEASE_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);

    kpemu_state_t  state;
    logic [CW-1:0] cnt;
    logic [3:0]    key_q;
    logic          aborted;
    logic [3:0]    row_mask;
    logic [3:0]    col_mask;
    logic          match;
    logic [3:0]    rows_nxt;

    keypad_key_decode u_decode (
        .key      (key_q),
        .row_mask (row_mask),
        .col_mask (col_mask)
    );

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [3:0] lfsr;
    logic       in_bounce;

    // x^4+x^3+1 noise source, free-running from a fixed seed
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 4'b1001;
        else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign in_bounce = (32'(cnt) < BOUNCE_CYCLES);

    // Row sense: contact chatters at the start of both press and release
    always_comb begin
        rows_nxt = '0;
        match    = |(cols & col_mask);
        if (state == PRESS && match && (!in_bounce || lfsr[0]))
            rows_nxt = row_mask;
        else if (state == RELEASE && in_bounce && match && lfsr[0])
            rows_nxt = row_mask;
    end
`else
    // Row sense: clean contact, asserted only while pressed and our column is driven
    always_comb begin
        rows_nxt = '0;
        match    = |(cols & col_mask);
        if (state == PRESS && match)
            rows_nxt = row_mask;
    end
`endif

    // Press/release sequencer with registered rows, done and completion count
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_q       <= '0;
            aborted     <= 1'b0;
            rows        <= '0;
            done        <= 1'b0;
            press_count <= '0;
        end else begin
            rows <= rows_nxt;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_q   <= key_code;
                        cnt     <= '0;
                        aborted <= 1'b0;
                        state   <= PRESS;
                    end
                end
                PRESS: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        cnt     <= '0;
                        state   <= RELEASE;
                    end else if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == REL_LAST) begin
                        cnt     <= '0;
                        done    <= 1'b1;
                        aborted <= 1'b0;
                        if (!aborted) press_count <= press_count + 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
